// File: rtl/usb_in_packetizer_pkg.sv
// Shared types and width helpers for the USB IN packetizer.
// State encoding for the packetizer FSM and a counter-width helper.
package usb_in_packetizer_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HELD  = 2'd1,
    ST_SEND  = 2'd2
  } state_t;

  // Bits needed to hold the values 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/usb_in_packetizer_if.sv
// FWFT fifo read side plus the valid/ready packet stream of the IN packetizer.
// master = packetizer view, slave = fifo/endpoint view.
interface usb_in_packetizer_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] pkt_data;
  logic                  pkt_valid;
  logic                  pkt_last;
  logic                  pkt_ready;

  modport master (
    input  fifo_data,
    input  fifo_empty,
    input  pkt_ready,
    output fifo_rd_en,
    output pkt_data,
    output pkt_valid,
    output pkt_last
  );

  modport slave (
    output fifo_data,
    output fifo_empty,
    output pkt_ready,
    input  fifo_rd_en,
    input  pkt_data,
    input  pkt_valid,
    input  pkt_last
  );

endinterface

// File: rtl/usb_in_packetizer_idle_timer.sv
// Idle-cycle timer: clears on load, counts while enabled, flags terminal count TIMEOUT-1.
// The count saturates at terminal so a stalled enable cannot wrap back to zero.
module usb_in_packetizer_idle_timer
  import usb_in_packetizer_pkg::*;
#(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int            TW   = cnt_w(TIMEOUT);
  localparam logic [TW-1:0] TERM = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + TW'(1);
    end
  end

  assign tc = (cnt == TERM);

endmodule

// File: rtl/usb_in_packetizer.sv
// Frames FWFT fifo bytes into USB IN packets, holding back one byte so that
// pkt_last is known before the byte is offered (size limit or idle timeout).
module usb_in_packetizer
  import usb_in_packetizer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_PKT    = 64,
  parameter int TIMEOUT    = 1000
) (
  input  logic                clk,
  input  logic                rst,
  usb_in_packetizer_if.master bus
);

  localparam int            CW      = cnt_w(MAX_PKT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PKT);

  state_t                state;
  logic [DATA_WIDTH-1:0] data_p0;
  logic                  last_p0;
  logic                  vld_p0;
  logic [CW-1:0]         beat_cnt;

  logic accept;
  logic pop;
  logic timer_en;
  logic timer_tc;

  assign accept = (state == ST_SEND) && bus.pkt_ready;
  assign pop    = !rst && !bus.fifo_empty && ((state == ST_EMPTY) || accept);

  // Only count idle cycles that would actually reach the timeout branch.
  assign timer_en = (state == ST_HELD) && (beat_cnt != MAX_CNT) && bus.fifo_empty;

  usb_in_packetizer_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk (clk),
    .rst (rst),
    .clr (pop),
    .en  (timer_en),
    .tc  (timer_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_EMPTY;
      vld_p0   <= 1'b0;
      last_p0  <= 1'b0;
      data_p0  <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (!bus.fifo_empty) begin
            data_p0  <= bus.fifo_data;
            beat_cnt <= beat_cnt + CW'(1);
            state    <= ST_HELD;
          end
        end
        ST_HELD: begin
          // A waiting fifo word beats the timeout: the held byte is not final.
          if (beat_cnt == MAX_CNT) begin
            last_p0 <= 1'b1;
            vld_p0  <= 1'b1;
            state   <= ST_SEND;
          end else if (!bus.fifo_empty) begin
            last_p0 <= 1'b0;
            vld_p0  <= 1'b1;
            state   <= ST_SEND;
          end else if (timer_tc) begin
            last_p0 <= 1'b1;
            vld_p0  <= 1'b1;
            state   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (bus.pkt_ready) begin
            vld_p0 <= 1'b0;
            if (!bus.fifo_empty) begin
              data_p0  <= bus.fifo_data;
              beat_cnt <= last_p0 ? CW'(1) : beat_cnt + CW'(1);
              state    <= ST_HELD;
            end else begin
              if (last_p0) begin
                beat_cnt <= '0;
              end
              state <= ST_EMPTY;
            end
          end
        end
        default: begin
          vld_p0 <= 1'b0;
          state  <= ST_EMPTY;
        end
      endcase
    end
  end

  assign bus.fifo_rd_en = pop;
  assign bus.pkt_data   = data_p0;
  assign bus.pkt_valid  = vld_p0;
  assign bus.pkt_last   = last_p0;

endmodule

// File: tb/tb_usb_in_packetizer.sv
// Directed bench for usb_in_packetizer with a bench-side FWFT fifo and a beat recorder.
module tb_usb_in_packetizer;

  localparam int DW   = 8;
  localparam int MAXP = 64;
  localparam int TMO  = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic gate = 1'b0;

  always #5 clk = ~clk;

  usb_in_packetizer_if #(.DATA_WIDTH(DW)) bus ();

  usb_in_packetizer #(
    .DATA_WIDTH (DW),
    .MAX_PKT    (MAXP),
    .TIMEOUT    (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem      [8192];
  logic [7:0] out_data [8192];
  logic       out_last [8192];
  int wr_ptr   = 0;
  int rd_ptr   = 0;
  int out_cnt  = 0;
  int viol_cnt = 0;
  int n_vec    = 0;
  int n_err    = 0;

  assign bus.fifo_empty = gate || (rd_ptr == wr_ptr);
  assign bus.fifo_data  = mem[rd_ptr[12:0]];

  // Fifo read pointer, accepted-beat recorder and pop-while-empty watch.
  always @(posedge clk) begin
    if (bus.fifo_rd_en) rd_ptr <= rd_ptr + 1;
    if (bus.fifo_rd_en && bus.fifo_empty) viol_cnt <= viol_cnt + 1;
    if (!rst && bus.pkt_valid && bus.pkt_ready) begin
      out_data[out_cnt[12:0]] <= bus.pkt_data;
      out_last[out_cnt[12:0]] <= bus.pkt_last;
      out_cnt <= out_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[12:0]] = b;
    wr_ptr++;
  endtask

  task automatic wait_out(input int n, input int budget, input string tag);
    int c;
    c = 0;
    while (out_cnt < n && c < budget) begin
      step(1);
      c++;
    end
    check(tag, 32'(out_cnt >= n), 32'(1));
  endtask

  initial begin
    int c;
    int o;
    int s;
    int n6;
    int errs;
    int run;
    int maxrun;
    logic [8:0] e;

    // Reset with bytes already waiting: nothing may be popped or shown.
    bus.pkt_ready = 1'b0;
    rst = 1'b1;
    push(8'hA1);
    push(8'hB2);
    push(8'hC3);
    step(3);
    check("rst_valid", 32'(bus.pkt_valid), 32'(0));
    check("rst_last",  32'(bus.pkt_last),  32'(0));
    check("rst_data",  32'(bus.pkt_data),  32'(0));
    check("rst_rd_en", 32'(bus.fifo_rd_en), 32'(0));

    // Three bytes then idle: last byte closes only after TIMEOUT idle cycles.
    bus.pkt_ready = 1'b1;
    rst = 1'b0;
    wait_out(2, 50, "t1_wait_ab");
    c = 0;
    while (!bus.pkt_valid && c < 2000) begin
      step(1);
      c++;
    end
    check("t1_idle_gap", 32'(c), 32'(TMO));
    wait_out(3, 10, "t1_wait_c");
    check("t1_beat0", 32'({out_last[0], out_data[0]}), 32'({1'b0, 8'hA1}));
    check("t1_beat1", 32'({out_last[1], out_data[1]}), 32'({1'b0, 8'hB2}));
    check("t1_beat2", 32'({out_last[2], out_data[2]}), 32'({1'b1, 8'hC3}));

    // 130 bytes: packets of 64, 64, 2.
    o = out_cnt;
    for (int i = 0; i < 130; i++) push(8'(i));
    wait_out(o + 130, 1800, "t2_wait");
    for (int k = 0; k < 130; k++) begin
      e = {(k == 63 || k == 127 || k == 129), 8'(k)};
      check("t2_beat", 32'({out_last[(o + k) % 8192], out_data[(o + k) % 8192]}), 32'(e));
    end

    // Stall in SEND for 50 cycles with another word waiting in the fifo.
    o = out_cnt;
    bus.pkt_ready = 1'b0;
    push(8'h3C);
    push(8'h4D);
    c = 0;
    while (!bus.pkt_valid && c < 20) begin
      step(1);
      c++;
    end
    check("t3_valid_seen", 32'(bus.pkt_valid), 32'(1));
    for (int i = 0; i < 50; i++) begin
      check("t3_stall", 32'({bus.pkt_valid, bus.pkt_last, bus.fifo_rd_en, bus.pkt_data}),
            32'({1'b1, 1'b0, 1'b0, 8'h3C}));
      step(1);
    end
    bus.pkt_ready = 1'b1;
    wait_out(o + 2, 1100, "t3_wait");
    check("t3_beat0", 32'({out_last[o % 8192], out_data[o % 8192]}), 32'({1'b0, 8'h3C}));
    check("t3_beat1", 32'({out_last[(o + 1) % 8192], out_data[(o + 1) % 8192]}), 32'({1'b1, 8'h4D}));

    // Second byte shows up exactly on the terminal-count cycle.
    o = out_cnt;
    push(8'h77);
    step(TMO);
    push(8'h88);
    wait_out(o + 2, 1100, "t4_wait");
    check("t4_held_not_last", 32'({out_last[o % 8192], out_data[o % 8192]}), 32'({1'b0, 8'h77}));
    check("t4_new_byte", 32'({out_last[(o + 1) % 8192], out_data[(o + 1) % 8192]}), 32'({1'b1, 8'h88}));

    // Reset while the 10th byte of a packet is being offered.
    o = out_cnt;
    for (int i = 0; i < 11; i++) push(8'(8'h40 + i));
    wait_out(o + 9, 40, "t5_wait9");
    check("t5_beat8", 32'({out_last[(o + 8) % 8192], out_data[(o + 8) % 8192]}), 32'({1'b0, 8'h48}));
    bus.pkt_ready = 1'b0;
    step(1);
    check("t5_send10", 32'({bus.pkt_valid, bus.pkt_data}), 32'({1'b1, 8'h49}));
    rst = 1'b1;
    step(1);
    check("t5_rst_valid", 32'(bus.pkt_valid), 32'(0));
    check("t5_rst_last",  32'(bus.pkt_last),  32'(0));
    check("t5_rst_data",  32'(bus.pkt_data),  32'(0));
    check("t5_rst_rd_en", 32'(bus.fifo_rd_en), 32'(0));
    rst = 1'b0;
    bus.pkt_ready = 1'b1;
    for (int i = 0; i < 63; i++) push(8'(8'h80 + i));
    o = o + 9;
    wait_out(o + 64, 300, "t5_wait64");
    for (int k = 0; k < 64; k++) begin
      e = (k == 0) ? {1'b0, 8'h4A} : {(k == 63), 8'(8'h80 + k - 1)};
      check("t5_beat", 32'({out_last[(o + k) % 8192], out_data[(o + k) % 8192]}), 32'(e));
    end

    // Random fifo gating and back-pressure, with quiet stretches for timeouts.
    o = out_cnt;
    s = wr_ptr;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      gate = ($urandom_range(0, 9) < 3);
      bus.pkt_ready = ($urandom_range(0, 9) < 6);
      if ((cyc % 2500) < 1300 && $urandom_range(0, 3) == 0) push(8'($urandom_range(0, 255)));
      step(1);
    end
    gate = 1'b0;
    bus.pkt_ready = 1'b1;
    n6 = wr_ptr - s;
    wait_out(o + n6, 5000, "t6_drain");
    errs = 0;
    run = 0;
    maxrun = 0;
    for (int k = 0; k < n6; k++) begin
      if (out_data[(o + k) % 8192] !== mem[(s + k) % 8192]) errs++;
      run++;
      if (run > maxrun) maxrun = run;
      if (out_last[(o + k) % 8192]) run = 0;
    end
    check("t6_count", 32'(out_cnt - o), 32'(n6));
    check("t6_data_errs", 32'(errs), 32'(0));
    check("t6_pkt_le_max", 32'(maxrun <= MAXP), 32'(1));
    check("t6_final_last", 32'(out_last[(o + n6 - 1) % 8192]), 32'(1));
    check("t6_fifo_drained", 32'(rd_ptr), 32'(wr_ptr));
    check("pop_while_empty", 32'(viol_cnt), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
